// File: rtl/bus_master_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_master_port
//  Description : Master-side endpoint of the shared system bus. Turns one
//                local user request into a full bus cycle: request, grant
//                wait (bounded), address/data phase, optional read-data
//                collection, then bus release with a done/error pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_master_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // user side
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    // arbiter side
    output logic                  breq,
    input  logic                  bgrant,
    // bus side
    output logic                  m_valid,
    output logic                  m_write,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  s_ready,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // TIMEOUT=0 (wait forever) build still has a legal vector.
    localparam int CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  err_flag;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Control strobes produced by the next-state logic for the datapath
    logic                  accept;
    logic                  cnt_inc;
    logic                  err_set;
    logic                  rd_capture;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        rd_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // A grant arriving on the last allowed cycle still wins
                if (bgrant) begin
                    state_nxt = ST_ADDR;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (TO_EN) begin
                    cnt_inc = 1'b1;
                end
            end
            ST_ADDR: begin
                // Losing the bus invalidates the phase even if a slave answered
                if (!bgrant) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (s_ready) begin
                    state_nxt = lat_write ? ST_DONE : ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (s_rvalid) begin
                    rd_capture = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (!bgrant) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, grant-wait counter, error flag and read-data holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            err_flag  <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_write <= d_write;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                cnt       <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_DONE) begin
                err_flag <= 1'b0;
            end else if (err_set) begin
                err_flag <= 1'b1;
            end
            if (rd_capture) begin
                rdata_q <= s_rdata;
            end
        end
    end

    // All handshake outputs are decoded from the registered state
    assign d_ready = (state == ST_IDLE);
    assign breq    = (state == ST_REQ) || (state == ST_ADDR) || (state == ST_RDATA);
    assign m_valid = (state == ST_ADDR);
    assign d_done  = (state == ST_DONE);
    assign d_err   = (state == ST_DONE) && err_flag;
    assign m_write = lat_write;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign d_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_master_port
//  Description : Self-checking bench for bus_master_port. One main instance
//                driven directly, a TIMEOUT=4 instance for the grant-wait
//                bound, and a second master sharing a small arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_master_port;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // shared request/slave stimulus
    logic        d_write  = 1'b0;
    logic [15:0] d_addr   = '0;
    logic [7:0]  d_wdata  = '0;
    logic        s_ready  = 1'b0;
    logic        s_rvalid = 1'b0;
    logic [7:0]  s_rdata  = '0;

    // main instance
    logic        d_valid0  = 1'b0;
    logic        tb_bgrant = 1'b0;
    logic        bgrant0;
    logic        d_ready0, d_done0, d_err0, breq0, m_valid0, m_write0;
    logic [7:0]  d_rdata0, m_wdata0;
    logic [15:0] m_addr0;

    // second master for the arbitration scenario
    logic        d_valid1 = 1'b0;
    logic [15:0] d_addr1  = 16'h2000;
    logic        bgrant1;
    logic        d_ready1, d_done1, d_err1, breq1, m_valid1, m_write1;
    logic [7:0]  d_rdata1, m_wdata1;
    logic [15:0] m_addr1;

    // short-timeout instance
    logic        d_valid_to = 1'b0;
    logic        bgrant_to  = 1'b0;
    logic        d_ready_to, d_done_to, d_err_to, breq_to, m_valid_to, m_write_to;
    logic [7:0]  d_rdata_to, m_wdata_to;
    logic [15:0] m_addr_to;

    // arbiter model
    logic        arb_mode = 1'b0;
    logic [1:0]  owner;
    logic        arb_g0, arb_g1;

    int          errors = 0;
    int          checks = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  model_rdata = 8'h00;

    int          mv_cnt;
    logic        cap_write;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;

    always #5 clk = ~clk;

    assign bgrant0 = arb_mode ? arb_g0 : tb_bgrant;
    assign bgrant1 = arb_g1;
    assign arb_g0  = (owner == 2'd1);
    assign arb_g1  = (owner == 2'd2);

    // Registered two-master arbiter: master 0 wins ties, owner keeps the bus until breq drops
    always_ff @(posedge clk) begin
        if (rst || !arb_mode) begin
            owner <= 2'd0;
        end else begin
            case (owner)
                2'd0:    owner <= breq0 ? 2'd1 : (breq1 ? 2'd2 : 2'd0);
                2'd1:    owner <= breq0 ? 2'd1 : 2'd0;
                2'd2:    owner <= breq1 ? 2'd2 : 2'd0;
                default: owner <= 2'd0;
            endcase
        end
    end

    bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(255)) u_dut0 (
        .clk(clk), .rst(rst),
        .d_valid(d_valid0), .d_ready(d_ready0), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata0), .d_done(d_done0), .d_err(d_err0),
        .breq(breq0), .bgrant(bgrant0),
        .m_valid(m_valid0), .m_write(m_write0), .m_addr(m_addr0), .m_wdata(m_wdata0),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .d_valid(d_valid1), .d_ready(d_ready1), .d_write(d_write), .d_addr(d_addr1),
        .d_wdata(d_wdata), .d_rdata(d_rdata1), .d_done(d_done1), .d_err(d_err1),
        .breq(breq1), .bgrant(bgrant1),
        .m_valid(m_valid1), .m_write(m_write1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .d_valid(d_valid_to), .d_ready(d_ready_to), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata_to), .d_done(d_done_to), .d_err(d_err_to),
        .breq(breq_to), .bgrant(bgrant_to),
        .m_valid(m_valid_to), .m_write(m_write_to), .m_addr(m_addr_to), .m_wdata(m_wdata_to),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    // Advance to the next falling edge and record the main instance's address phase
    task automatic tick();
        @(negedge clk);
        if (m_valid0) begin
            mv_cnt++;
            cap_write = m_write0;
            cap_addr  = m_addr0;
            cap_wdata = m_wdata0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({d_ready0, breq0, m_valid0, d_done0, d_err0} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000", {d_ready0, breq0, m_valid0, d_done0, d_err0});
        end
        checks++;
        if ({d_rdata0, m_addr0, m_wdata0, m_write0} !== 33'h0) begin
            errors++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h write=%b expected zeros",
                     d_rdata0, m_addr0, m_wdata0, m_write0);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        exp_t e;
        bit   got;
        tick();
        d_valid0 = 1'b1; d_write = 1'b1; d_addr = 16'h1234; d_wdata = 8'hA5;
        tb_bgrant = 1'b0; s_ready = 1'b1; s_rvalid = 1'b0;
        e.err = 1'b0; e.rdata = model_rdata; q0.push_back(e);
        mv_cnt = 0;
        tick(); d_valid0 = 1'b0;
        tick();
        tick(); tb_bgrant = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (d_done0) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL write_done: got no d_done expected one within 20 cycles"); end
        else if (q0.size() == 0) begin errors++; $display("FAIL write_sb: got d_done expected none queued"); end
        else begin
            e = q0.pop_front();
            checks++;
            if ({d_err0, d_rdata0} !== {e.err, e.rdata}) begin
                errors++;
                $display("FAIL write_result: got err=%b rdata=%h expected err=%b rdata=%h", d_err0, d_rdata0, e.err, e.rdata);
            end
        end
        checks++;
        if (mv_cnt !== 1) begin errors++; $display("FAIL write_mvalid_len: got %0d expected 1", mv_cnt); end
        checks++;
        if ({cap_write, cap_addr, cap_wdata} !== {1'b1, 16'h1234, 8'hA5}) begin
            errors++;
            $display("FAIL write_fields: got w=%b a=%h d=%h expected w=1 a=1234 d=a5", cap_write, cap_addr, cap_wdata);
        end
        tb_bgrant = 1'b0;
        tick();
        checks++;
        if ({breq0, d_done0, d_ready0} !== 3'b001) begin
            errors++;
            $display("FAIL write_after: got breq/done/ready=%b expected 001", {breq0, d_done0, d_ready0});
        end
    endtask

    task automatic test_read();
        exp_t e;
        bit   got;
        bit   in_rd;
        tick();
        d_valid0 = 1'b1; d_write = 1'b0; d_addr = 16'h0042;
        tb_bgrant = 1'b1; s_ready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 8'hEE;      // stray data outside RDATA must be ignored
        model_rdata = 8'h5C;
        e.err = 1'b0; e.rdata = model_rdata; q0.push_back(e);
        mv_cnt = 0; got = 1'b0; in_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            d_valid0 = 1'b0;
            if (d_done0) begin got = 1'b1; break; end
            if (m_valid0 && mv_cnt == 3) begin s_ready = 1'b1; s_rvalid = 1'b0; end
            if (breq0 && !m_valid0 && mv_cnt > 0) begin
                in_rd = 1'b1; s_rvalid = 1'b1; s_rdata = 8'h5C;
            end
        end
        s_rvalid = 1'b0; s_ready = 1'b1; tb_bgrant = 1'b0;
        checks++;
        if (!got || !in_rd) begin errors++; $display("FAIL read_done: got done=%b rdata_phase=%b expected 1 1", got, in_rd); end
        else if (q0.size() == 0) begin errors++; $display("FAIL read_sb: got d_done expected none queued"); end
        else begin
            e = q0.pop_front();
            checks++;
            if ({d_err0, d_rdata0} !== {e.err, e.rdata}) begin
                errors++;
                $display("FAIL read_result: got err=%b rdata=%h expected err=%b rdata=%h", d_err0, d_rdata0, e.err, e.rdata);
            end
        end
        checks++;
        if (mv_cnt !== 3) begin errors++; $display("FAIL read_mvalid_stall: got %0d expected 3", mv_cnt); end
        checks++;
        if ({cap_write, cap_addr} !== {1'b0, 16'h0042}) begin
            errors++;
            $display("FAIL read_fields: got w=%b a=%h expected w=0 a=0042", cap_write, cap_addr);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   got;
        int   cnt;
        // no grant at all: four request cycles, then an error completion
        tick();
        d_valid_to = 1'b1; d_write = 1'b1; d_addr = 16'h0100; d_wdata = 8'h77; bgrant_to = 1'b0;
        e.err = 1'b1; e.rdata = 8'h00; q0.push_back(e);
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            d_valid_to = 1'b0;
            if (breq_to) cnt++;
            if (d_done_to) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL to_done: got no d_done expected one"); end
        else if (q0.size() == 0) begin errors++; $display("FAIL to_sb: got d_done expected none queued"); end
        else begin
            e = q0.pop_front();
            checks++;
            if ({d_err_to, d_rdata_to} !== {e.err, e.rdata}) begin
                errors++;
                $display("FAIL to_result: got err=%b rdata=%h expected err=%b rdata=%h", d_err_to, d_rdata_to, e.err, e.rdata);
            end
        end
        checks++;
        if (cnt !== 4) begin errors++; $display("FAIL to_breq_len: got %0d expected 4", cnt); end
        tick();
        checks++;
        if ({d_ready_to, d_done_to} !== 2'b10) begin
            errors++;
            $display("FAIL to_ready_after: got ready/done=%b expected 10", {d_ready_to, d_done_to});
        end
        // grant on the fourth request cycle: grant wins over the timeout
        d_valid_to = 1'b1; s_ready = 1'b1;
        e.err = 1'b0; e.rdata = 8'h00; q0.push_back(e);
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            d_valid_to = 1'b0;
            if (breq_to) cnt++;
            if (breq_to && !m_valid_to && cnt == 4) bgrant_to = 1'b1;
            if (m_valid_to) begin
                checks++;
                if ({m_write_to, m_addr_to, m_wdata_to} !== {1'b1, 16'h0100, 8'h77}) begin
                    errors++;
                    $display("FAIL to_fields: got w=%b a=%h d=%h expected w=1 a=0100 d=77", m_write_to, m_addr_to, m_wdata_to);
                end
            end
            if (d_done_to) begin got = 1'b1; break; end
        end
        bgrant_to = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL to_grant_done: got no d_done expected one"); end
        else if (q0.size() == 0) begin errors++; $display("FAIL to_grant_sb: got d_done expected none queued"); end
        else begin
            e = q0.pop_front();
            checks++;
            if (d_err_to !== e.err) begin errors++; $display("FAIL to_grant_err: got %b expected %b", d_err_to, e.err); end
        end
        checks++;
        if (cnt !== 5) begin errors++; $display("FAIL to_grant_breq_len: got %0d expected 5", cnt); end
    endtask

    task automatic test_grant_lost();
        exp_t e;
        bit   got;
        tick();
        d_valid0 = 1'b1; d_write = 1'b0; d_addr = 16'h0043;
        tb_bgrant = 1'b1; s_ready = 1'b1; s_rvalid = 1'b0; s_rdata = 8'hEE;
        e.err = 1'b1; e.rdata = model_rdata; q0.push_back(e);
        mv_cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            d_valid0 = 1'b0;
            if (d_done0) begin got = 1'b1; break; end
            if (breq0 && !m_valid0 && mv_cnt > 0) tb_bgrant = 1'b0;
        end
        tb_bgrant = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL lost_done: got no d_done expected one"); end
        else if (q0.size() == 0) begin errors++; $display("FAIL lost_sb: got d_done expected none queued"); end
        else begin
            e = q0.pop_front();
            checks++;
            if ({d_err0, d_rdata0} !== {e.err, e.rdata}) begin
                errors++;
                $display("FAIL lost_result: got err=%b rdata=%h expected err=%b rdata=%h", d_err0, d_rdata0, e.err, e.rdata);
            end
        end
        tick();
        checks++;
        if ({d_done0, d_err0, d_rdata0} !== {2'b00, model_rdata}) begin
            errors++;
            $display("FAIL lost_hold: got done=%b err=%b rdata=%h expected 0 0 %h", d_done0, d_err0, d_rdata0, model_rdata);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        int   ndone;
        tick();
        d_valid0 = 1'b1; d_write = 1'b1; d_addr = 16'h0555; d_wdata = 8'h11;
        tb_bgrant = 1'b1; s_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            d_valid0 = 1'b0;
            if (m_valid0) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rstmid_addr: got no m_valid expected address phase"); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rdata = 8'h00;
        checks++;
        if ({breq0, m_valid0, d_done0, d_ready0, d_rdata0} !== {4'b0001, model_rdata}) begin
            errors++;
            $display("FAIL rstmid_state: got breq/mv/done/ready=%b rdata=%h expected 0001 00",
                     {breq0, m_valid0, d_done0, d_ready0}, d_rdata0);
        end
        ndone = 0;
        repeat (3) begin tick(); if (d_done0) ndone++; end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL rstmid_nodone: got %0d d_done pulses expected 0", ndone); end
        d_valid0 = 1'b1; d_addr = 16'h0666; d_wdata = 8'h22; s_ready = 1'b1;
        e.err = 1'b0; e.rdata = model_rdata; q0.push_back(e);
        mv_cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            d_valid0 = 1'b0;
            if (d_done0) begin got = 1'b1; break; end
        end
        tb_bgrant = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL rstmid_next: got no d_done expected one"); end
        else if (q0.size() == 0) begin errors++; $display("FAIL rstmid_sb: got d_done expected none queued"); end
        else begin
            e = q0.pop_front();
            checks++;
            if ({d_err0, d_rdata0, cap_addr, cap_wdata} !== {e.err, e.rdata, 16'h0666, 8'h22}) begin
                errors++;
                $display("FAIL rstmid_result: got err=%b rdata=%h a=%h d=%h expected err=%b rdata=%h a=0666 d=22",
                         d_err0, d_rdata0, cap_addr, cap_wdata, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acc0, acc1, done0, done1, low0, low1;
        bit   prev0, prev1;
        tick();
        arb_mode = 1'b1; s_ready = 1'b1; s_rvalid = 1'b0;
        d_write = 1'b1; d_wdata = 8'h3C; d_addr = 16'h1000; d_addr1 = 16'h2000;
        d_valid0 = 1'b1; d_valid1 = 1'b1;
        acc0 = 0; acc1 = 0; done0 = 0; done1 = 0; low0 = 99; low1 = 99;
        prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 300 && !(done0 == 3 && done1 == 3); i++) begin
            if (d_done0) begin
                done0++;
                checks++;
                if (q0.size() == 0) begin errors++; $display("FAIL b2b_sb0: got extra d_done expected none"); end
                else begin
                    e = q0.pop_front();
                    if ({d_err0, d_rdata0} !== {e.err, e.rdata}) begin
                        errors++;
                        $display("FAIL b2b_result0: got err=%b rdata=%h expected err=%b rdata=%h", d_err0, d_rdata0, e.err, e.rdata);
                    end
                end
            end
            if (d_done1) begin
                done1++;
                checks++;
                if (q1.size() == 0) begin errors++; $display("FAIL b2b_sb1: got extra d_done expected none"); end
                else begin
                    e = q1.pop_front();
                    if ({d_err1, d_rdata1} !== {e.err, e.rdata}) begin
                        errors++;
                        $display("FAIL b2b_result1: got err=%b rdata=%h expected err=%b rdata=%h", d_err1, d_rdata1, e.err, e.rdata);
                    end
                end
            end
            if (m_valid0 || m_valid1) begin
                checks++;
                if (m_valid0 && m_valid1) begin errors++; $display("FAIL b2b_overlap: got both m_valid expected one"); end
                else if (m_valid0 && {m_write0, m_addr0, m_wdata0} !== {1'b1, 16'h1000, 8'h3C}) begin
                    errors++; $display("FAIL b2b_fields0: got a=%h d=%h expected a=1000 d=3c", m_addr0, m_wdata0);
                end
                else if (m_valid1 && {m_write1, m_addr1, m_wdata1} !== {1'b1, 16'h2000, 8'h3C}) begin
                    errors++; $display("FAIL b2b_fields1: got a=%h d=%h expected a=2000 d=3c", m_addr1, m_wdata1);
                end
            end
            if (breq0 && !prev0) begin
                checks++;
                if (low0 < 2) begin errors++; $display("FAIL b2b_gap0: got %0d low cycles expected >=2", low0); end
            end
            if (breq1 && !prev1) begin
                checks++;
                if (low1 < 2) begin errors++; $display("FAIL b2b_gap1: got %0d low cycles expected >=2", low1); end
            end
            low0 = breq0 ? 0 : low0 + 1;
            low1 = breq1 ? 0 : low1 + 1;
            prev0 = breq0; prev1 = breq1;
            // requests are held high; only those seen while ready are accepted
            if (d_ready0) begin
                if (acc0 < 3) begin e.err = 1'b0; e.rdata = model_rdata; q0.push_back(e); acc0++; end
                else d_valid0 = 1'b0;
            end
            if (d_ready1) begin
                if (acc1 < 3) begin e.err = 1'b0; e.rdata = 8'h00; q1.push_back(e); acc1++; end
                else d_valid1 = 1'b0;
            end
            @(negedge clk);
        end
        d_valid0 = 1'b0; d_valid1 = 1'b0;
        checks++;
        if (done0 !== 3 || done1 !== 3) begin
            errors++;
            $display("FAIL b2b_count: got done0=%0d done1=%0d expected 3 3", done0, done1);
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        repeat (3) @(negedge clk);
        arb_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_grant_lost();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
